// File: rtl/wb_dest_tracker_if.sv
// Issue/writeback bundle for the destination tracker: the instruction presented
// for issue, the hazard answer, and the writeback stream.
interface wb_dest_if #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 3
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              issue_valid;
   logic [ADDR_W-1:0] rt;
   logic [ADDR_W-1:0] rd;
   logic              reg_dst;
   logic              jal;
   logic              reg_write;
   logic [ADDR_W-1:0] src_a;
   logic [ADDR_W-1:0] src_b;
   logic              src_a_used;
   logic              src_b_used;
   logic              flush;
   logic [ADDR_W-1:0] dest;
   logic              stall;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [CNT_W-1:0]  pending;

   modport master (
      output issue_valid, rt, rd, reg_dst, jal, reg_write,
             src_a, src_b, src_a_used, src_b_used, flush,
      input  dest, stall, wb_valid, wb_addr, pending
   );

   modport slave (
      input  issue_valid, rt, rd, reg_dst, jal, reg_write,
             src_a, src_b, src_a_used, src_b_used, flush,
      output dest, stall, wb_valid, wb_addr, pending
   );
endinterface

// File: rtl/wb_dest_tracker.sv
// Tracks in-flight register destinations from issue to writeback and raises a
// RAW stall when a presented instruction reads a register not yet written back.
module wb_dest_tracker #(
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 3,
   parameter int LINK_REG = 31
) (
   input logic   clk,
   input logic   rst_n,
   wb_dest_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   if (DEPTH < 2 || DEPTH > 8) begin : g_depth_check
      $error("wb_dest_tracker: DEPTH must be in 2..8");
   end

   logic [DEPTH-1:0]  vld_p;
   logic [ADDR_W-1:0] addr_p [DEPTH];
   logic [ADDR_W-1:0] dest;
   logic              hit_a;
   logic              hit_b;
   logic              stall;
   logic              accept;

   function automatic logic [ADDR_W-1:0] sel_dest(
      input logic              jal_i,
      input logic              reg_dst_i,
      input logic [ADDR_W-1:0] rt_i,
      input logic [ADDR_W-1:0] rd_i
   );
      if (jal_i)          return ADDR_W'(LINK_REG);
      else if (reg_dst_i) return rd_i;
      else                return rt_i;
   endfunction

   function automatic logic [CNT_W-1:0] count_valid(input logic [DEPTH-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < DEPTH; i++) n = n + CNT_W'(v[i]);
      return n;
   endfunction

   assign dest = sel_dest(bus.jal, bus.reg_dst, bus.rt, bus.rd);

   // The writeback stage is excluded: the register file writes before it reads.
   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (vld_p[i] && (addr_p[i] == bus.src_a)) hit_a = 1'b1;
         if (vld_p[i] && (addr_p[i] == bus.src_b)) hit_b = 1'b1;
      end
      stall = bus.issue_valid && !bus.flush &&
              ((bus.src_a_used && (bus.src_a != '0) && hit_a) ||
               (bus.src_b_used && (bus.src_b != '0) && hit_b));
   end

   assign accept = bus.issue_valid && !stall && !bus.flush;

   // Issue into stage 0 and shift every cycle; flush empties the whole pipe once
   // the current writeback-stage entry has been presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p <= '0;
         for (int i = 0; i < DEPTH; i++) addr_p[i] <= '0;
      end else if (bus.flush) begin
         vld_p <= '0;
         for (int i = 0; i < DEPTH; i++) addr_p[i] <= '0;
      end else begin
         vld_p[0]  <= accept && bus.reg_write && (dest != '0);
         addr_p[0] <= accept ? dest : '0;
         for (int i = 1; i < DEPTH; i++) begin
            vld_p[i]  <= vld_p[i-1];
            addr_p[i] <= addr_p[i-1];
         end
      end
   end

   assign bus.dest     = dest;
   assign bus.stall    = stall;
   assign bus.wb_valid = vld_p[DEPTH-1];
   assign bus.wb_addr  = addr_p[DEPTH-1];
   assign bus.pending  = count_valid(vld_p);
endmodule

// File: tb/tb_wb_dest_tracker.sv
// Directed bench for wb_dest_tracker (DEPTH=3) with a writeback scoreboard.
module tb_wb_dest_tracker;
   logic clk;
   logic rst_n;
   int   compared;
   int   fails;
   logic [4:0] sb [$];
   logic [4:0] exp_wb;

   wb_dest_if #(.ADDR_W(5), .DEPTH(3)) bus ();

   wb_dest_tracker #(.ADDR_W(5), .DEPTH(3), .LINK_REG(31)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      bus.issue_valid = 1'b0; bus.rt = '0; bus.rd = '0; bus.reg_dst = 1'b0;
      bus.jal = 1'b0; bus.reg_write = 1'b0; bus.src_a = '0; bus.src_b = '0;
      bus.src_a_used = 1'b0; bus.src_b_used = 1'b0; bus.flush = 1'b0;
   endtask

   // Present a writing instruction with destination rt and no used sources.
   task automatic issue_rt(input logic [4:0] r);
      idle();
      bus.issue_valid = 1'b1; bus.rt = r; bus.reg_write = 1'b1;
   endtask

   // Writeback scoreboard: every writeback must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && bus.wb_valid) begin
         compared++;
         assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL wb_unexpected: observed addr %0d expected no writeback", bus.wb_addr);
         end
         if (sb.size() > 0) begin
            exp_wb = sb.pop_front();
            assert (bus.wb_addr === exp_wb) else begin
               fails++;
               $error("FAIL wb_addr: observed %0d expected %0d", bus.wb_addr, exp_wb);
            end
         end
      end
   end

   initial begin
      compared = 0;
      fails    = 0;
      rst_n    = 1'b0;
      idle();
      #3;
      chk("rst_wb_valid", bus.wb_valid, 0);
      chk("rst_pending", bus.pending, 0);
      chk("rst_stall", bus.stall, 0);
      tick(); tick();
      rst_n = 1'b1;

      // Single write to r5: visible in writeback after the third edge.
      issue_rt(5'd5);
      #1 chk("t1_dest", bus.dest, 5); chk("t1_stall", bus.stall, 0);
      sb.push_back(5'd5);
      tick(); idle();
      chk("t1_pend0", bus.pending, 1); chk("t1_wbv0", bus.wb_valid, 0);
      tick();
      chk("t1_pend1", bus.pending, 1); chk("t1_wbv1", bus.wb_valid, 0);
      tick();
      chk("t1_pend2", bus.pending, 1); chk("t1_wbv2", bus.wb_valid, 1);
      chk("t1_wba2", bus.wb_addr, 5);
      tick();
      chk("t1_pend3", bus.pending, 0); chk("t1_wbv3", bus.wb_valid, 0);

      // jal overrides reg_dst; r0 and non-writing issues create no entry.
      idle();
      bus.issue_valid = 1'b1; bus.jal = 1'b1; bus.reg_dst = 1'b1; bus.rd = 5'd7;
      bus.rt = 5'd2; bus.reg_write = 1'b1;
      #1 chk("t2_jal_dest", bus.dest, 31);
      sb.push_back(5'd31);
      tick();
      idle();
      bus.issue_valid = 1'b1; bus.reg_dst = 1'b1; bus.rd = 5'd0; bus.rt = 5'd3;
      bus.reg_write = 1'b1;
      #1 chk("t2_rd_dest", bus.dest, 0);
      tick();
      chk("t2_pend_r0", bus.pending, 1);
      issue_rt(5'd9); bus.reg_write = 1'b0;
      tick(); idle();
      chk("t2_pend_nowr", bus.pending, 1);
      repeat (4) tick();

      // RAW stall on r8 for two cycles, cleared once r8 reaches writeback.
      issue_rt(5'd8);
      sb.push_back(5'd8);
      tick();
      issue_rt(5'd10); bus.src_a = 5'd8; bus.src_a_used = 1'b1;
      #1 chk("t3_stall0", bus.stall, 1); chk("t3_dest", bus.dest, 10);
      tick();
      chk("t3_stall1", bus.stall, 1);
      tick();
      chk("t3_stall2", bus.stall, 0);
      sb.push_back(5'd10);
      tick(); idle();
      chk("t3_pend", bus.pending, 1);
      repeat (4) tick();

      // Unused or r0 sources, idle issue and flush never stall.
      issue_rt(5'd8);
      sb.push_back(5'd8);
      tick();
      issue_rt(5'd11); bus.reg_write = 1'b0;
      bus.src_b = 5'd8; bus.src_b_used = 1'b0; bus.src_a = 5'd0; bus.src_a_used = 1'b1;
      #1 chk("t4_stall_unused", bus.stall, 0);
      tick();
      idle(); bus.src_a = 5'd8; bus.src_a_used = 1'b1;
      #1 chk("t4_stall_noissue", bus.stall, 0);
      bus.issue_valid = 1'b1;
      #1 chk("t4_stall_hit", bus.stall, 1);
      bus.flush = 1'b1;
      #1 chk("t4_stall_flush", bus.stall, 0);
      idle();
      repeat (4) tick();

      // Flush with r3/r4/r5 in flight: only r5 is written back.
      issue_rt(5'd5); sb.push_back(5'd5); tick();
      issue_rt(5'd4); sb.push_back(5'd4); tick();
      issue_rt(5'd3); sb.push_back(5'd3); tick();
      idle();
      chk("t5_pend_full", bus.pending, 3);
      chk("t5_wba", bus.wb_addr, 5);
      issue_rt(5'd12); bus.flush = 1'b1;
      #1 chk("t5_flush_stall", bus.stall, 0);
      tick(); idle();
      sb.delete();
      chk("t5_pend_flushed", bus.pending, 0);
      chk("t5_wbv_flushed", bus.wb_valid, 0);
      repeat (3) tick();
      chk("t5_pend_later", bus.pending, 0);

      // Two writes to the same register are both retired in order.
      issue_rt(5'd6); sb.push_back(5'd6); tick();
      issue_rt(5'd6); sb.push_back(5'd6); tick();
      idle();
      chk("t6_pend_dup", bus.pending, 2);
      repeat (4) tick();

      // Asynchronous reset between edges empties the pipe at once.
      issue_rt(5'd1); sb.push_back(5'd1); tick();
      issue_rt(5'd2); sb.push_back(5'd2); tick();
      issue_rt(5'd3); sb.push_back(5'd3); tick();
      idle();
      chk("t7_pend_full", bus.pending, 3);
      #1 rst_n = 1'b0;
      sb.delete();
      #1 chk("t7_rst_wbv", bus.wb_valid, 0);
      chk("t7_rst_pend", bus.pending, 0);
      chk("t7_rst_wba", bus.wb_addr, 0);
      #2 rst_n = 1'b1;
      issue_rt(5'd9); sb.push_back(5'd9);
      tick(); idle();
      chk("t7_first_accept", bus.pending, 1);

      for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
      chk("sb_drain", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
      $finish;
   end
endmodule
